// File: rtl/bram_dp_unified_if.sv
// rtl/bram_dp_unified_if.sv - request/response bundle for one bram_dp_unified port
// The requester drives req/we/addr/data_in; the memory answers with data_out/rvalid/err.
interface bram_dp_unified_if #(
   parameter int DATA_W = 32
);
   localparam int NB = DATA_W / 8;

   logic              req;
   logic [NB-1:0]     we;
   logic [31:0]       addr;
   logic [DATA_W-1:0] data_in;
   logic [DATA_W-1:0] data_out;
   logic              rvalid;
   logic              err;

   modport master (output req, we, addr, data_in, input data_out, rvalid, err);
   modport slave  (input req, we, addr, data_in, output data_out, rvalid, err);
endinterface

// File: rtl/bram_dp_unified.sv
// rtl/bram_dp_unified.sv - unified true-dual-port word memory with byte lanes and clear sweep
// Optional macro BRAM_DP_BYPASS_EN: forward a same-cycle cross-port write to the reading port.
module bram_dp_unified #(
   parameter int DATA_W         = 32,
   parameter int DEPTH          = 128,
   parameter bit CLEAR_ON_RESET = 1'b1
) (
   input  logic             clk,
   input  logic             rst_n,
   output logic             ready,
   bram_dp_unified_if.slave port_i,
   bram_dp_unified_if.slave port_m
);
   localparam int          NB     = DATA_W / 8;
   localparam int          ADDR_W = $clog2(DEPTH);
   localparam logic [31:0] LIMIT  = 32'(DEPTH * 4);

   typedef enum logic {ST_INIT, ST_RUN} state_t;

   state_t            state_q;
   logic [ADDR_W-1:0] clr_q;
   logic              ready_q;
   logic [DATA_W-1:0] mem [DEPTH];

   logic              acc_i, acc_m;
   logic              err_i_d, err_m_d;
   logic              wr_i, wr_m;
   logic              same_word;
   logic [ADDR_W-1:0] idx_i, idx_m;
   logic [DATA_W-1:0] new_i_d, new_m_d;
   logic [DATA_W-1:0] rd_i_d, rd_m_d;

   logic [DATA_W-1:0] dout_i_q, dout_m_q;
   logic              rvalid_i_q, rvalid_m_q;
   logic              err_i_q, err_m_q;

   always_comb begin
      acc_i     = port_i.req && ready_q;
      acc_m     = port_m.req && ready_q;
      err_i_d   = (port_i.addr[1:0] != 2'b00) || (port_i.addr >= LIMIT);
      err_m_d   = (port_m.addr[1:0] != 2'b00) || (port_m.addr >= LIMIT);
      idx_i     = port_i.addr[ADDR_W+1:2];
      idx_m     = port_m.addr[ADDR_W+1:2];
      wr_i      = acc_i && !err_i_d && (port_i.we != '0);
      wr_m      = acc_m && !err_m_d && (port_m.we != '0);
      same_word = (idx_i == idx_m);

      // Both ports compute the fully merged word so a shared-word collision stores one value,
      // with port M lanes applied last.
      new_i_d = mem[idx_i];
      new_m_d = mem[idx_m];
      for (int k = 0; k < NB; k++) begin
         if (port_i.we[k]) new_i_d[k*8 +: 8] = port_i.data_in[k*8 +: 8];
         if (wr_i && same_word && port_i.we[k]) new_m_d[k*8 +: 8] = port_i.data_in[k*8 +: 8];
      end
      for (int k = 0; k < NB; k++) begin
         if (port_m.we[k]) new_m_d[k*8 +: 8] = port_m.data_in[k*8 +: 8];
         if (wr_m && same_word && port_m.we[k]) new_i_d[k*8 +: 8] = port_m.data_in[k*8 +: 8];
      end

      rd_i_d = mem[idx_i];
      rd_m_d = mem[idx_m];
`ifdef BRAM_DP_BYPASS_EN
      if (port_i.we == '0 && wr_m && same_word) rd_i_d = new_m_d;
      if (port_m.we == '0 && wr_i && same_word) rd_m_d = new_i_d;
`endif
   end

   // Array storage has no reset; the INIT sweep is what clears it.
   always_ff @(posedge clk) begin
      if (state_q == ST_INIT) begin
         if (CLEAR_ON_RESET) mem[clr_q] <= '0;
      end else begin
         if (wr_i) mem[idx_i] <= new_i_d;
         if (wr_m) mem[idx_m] <= new_m_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_INIT;
         clr_q      <= '0;
         ready_q    <= 1'b0;
         dout_i_q   <= '0;
         dout_m_q   <= '0;
         rvalid_i_q <= 1'b0;
         rvalid_m_q <= 1'b0;
         err_i_q    <= 1'b0;
         err_m_q    <= 1'b0;
      end else begin
         if (state_q == ST_INIT) begin
            if (!CLEAR_ON_RESET || clr_q == ADDR_W'(DEPTH - 1)) begin
               state_q <= ST_RUN;
               ready_q <= 1'b1;
            end else begin
               clr_q <= clr_q + 1'b1;
            end
         end

         rvalid_i_q <= acc_i;
         rvalid_m_q <= acc_m;
         err_i_q    <= acc_i && err_i_d;
         err_m_q    <= acc_m && err_m_d;
         if (acc_i) dout_i_q <= err_i_d ? '0 : rd_i_d;
         if (acc_m) dout_m_q <= err_m_d ? '0 : rd_m_d;
      end
   end

   assign ready           = ready_q;
   assign port_i.data_out = dout_i_q;
   assign port_i.rvalid   = rvalid_i_q;
   assign port_i.err      = err_i_q;
   assign port_m.data_out = dout_m_q;
   assign port_m.rvalid   = rvalid_m_q;
   assign port_m.err      = err_m_q;
endmodule

// File: tb/tb_bram_dp_unified.sv
// tb/tb_bram_dp_unified.sv - vector table plus response scoreboard for bram_dp_unified
// Expected responses are queued per port at drive time and matched on the cycle they are due.
module tb_bram_dp_unified;
   localparam int DEPTH = 128;

`ifdef BRAM_DP_BYPASS_EN
   localparam logic [31:0] EXP_T5   = 32'h3333_3333;
   localparam logic [31:0] EXP_EDGE = 32'h9900_0000;
`else
   localparam logic [31:0] EXP_T5   = 32'h1111_2222;
   localparam logic [31:0] EXP_EDGE = 32'h0000_0000;
`endif

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic ready;
   int   cyc = 0;

   bram_dp_unified_if #(.DATA_W(32)) bus_i ();
   bram_dp_unified_if #(.DATA_W(32)) bus_m ();

   bram_dp_unified #(.DATA_W(32), .DEPTH(DEPTH), .CLEAR_ON_RESET(1'b1)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .ready  (ready),
      .port_i (bus_i),
      .port_m (bus_m)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      string       name;
      logic        req_i;
      logic [3:0]  we_i;
      logic [31:0] addr_i, din_i, exp_i;
      logic        err_i;
      logic        req_m;
      logic [3:0]  we_m;
      logic [31:0] addr_m, din_m, exp_m;
      logic        err_m;
   } vec_t;

   typedef struct {
      string       name;
      logic [31:0] data;
      logic        err;
      int          due;
   } exp_t;

   exp_t q_i[$];
   exp_t q_m[$];
   vec_t vecs[$];
   int   n_pass = 0;
   int   n_total = 0;
   bit   mon_en = 1'b0;

   function automatic void check(string name, logic [31:0] act, logic [31:0] req);
      n_total++;
      if (act === req) n_pass++;
      else $display("FAIL %s: got %h required %h", name, act, req);
   endfunction

   function automatic vec_t mk(string n,
                               logic ri, logic [3:0] wi, logic [31:0] ai, logic [31:0] di,
                               logic [31:0] ei, logic eri,
                               logic rm, logic [3:0] wm, logic [31:0] am, logic [31:0] dm,
                               logic [31:0] em, logic erm);
      vec_t v;
      v.name = n;
      v.req_i = ri; v.we_i = wi; v.addr_i = ai; v.din_i = di; v.exp_i = ei; v.err_i = eri;
      v.req_m = rm; v.we_m = wm; v.addr_m = am; v.din_m = dm; v.exp_m = em; v.err_m = erm;
      return v;
   endfunction

   task automatic drive(input vec_t v);
      exp_t e;
      @(negedge clk);
      bus_i.req = v.req_i; bus_i.we = v.we_i; bus_i.addr = v.addr_i; bus_i.data_in = v.din_i;
      bus_m.req = v.req_m; bus_m.we = v.we_m; bus_m.addr = v.addr_m; bus_m.data_in = v.din_m;
      e.due = cyc + 1;
      if (v.req_i) begin
         e.name = {v.name, "/I"}; e.data = v.exp_i; e.err = v.err_i;
         q_i.push_back(e);
      end
      if (v.req_m) begin
         e.name = {v.name, "/M"}; e.data = v.exp_m; e.err = v.err_m;
         q_m.push_back(e);
      end
   endtask

   task automatic set_idle();
      bus_i.req = 1'b0; bus_i.we = '0; bus_i.addr = '0; bus_i.data_in = '0;
      bus_m.req = 1'b0; bus_m.we = '0; bus_m.addr = '0; bus_m.data_in = '0;
   endtask

   task automatic wait_ready(input string name);
      int n;
      n = 0;
      while (n < 400) begin
         @(negedge clk);
         n++;
         if (ready === 1'b1) break;
      end
      set_idle();
      check(name, 32'(n), 32'(DEPTH));
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (mon_en) begin
         if (q_i.size() > 0 && q_i[0].due == cyc) begin
            e = q_i.pop_front();
            check({e.name, " rvalid"}, 32'(bus_i.rvalid), 32'd1);
            check({e.name, " data"}, bus_i.data_out, e.data);
            check({e.name, " err"}, 32'(bus_i.err), 32'(e.err));
         end else if (bus_i.rvalid !== 1'b0) begin
            check("unexpected rvalid_i", 32'(bus_i.rvalid), 32'd0);
         end
         if (q_m.size() > 0 && q_m[0].due == cyc) begin
            e = q_m.pop_front();
            check({e.name, " rvalid"}, 32'(bus_m.rvalid), 32'd1);
            check({e.name, " data"}, bus_m.data_out, e.data);
            check({e.name, " err"}, 32'(bus_m.err), 32'(e.err));
         end else if (bus_m.rvalid !== 1'b0) begin
            check("unexpected rvalid_m", 32'(bus_m.rvalid), 32'd0);
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL global timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      set_idle();
      //        name            I: req we     addr          din           exp           err   M: req we     addr          din           exp           err
      vecs.push_back(mk("T2 full",    0, 4'h0, 32'h000, 32'h0,         32'h0,         0,    1, 4'hF, 32'h010, 32'hDEADBEEF, 32'h0,         0));
      vecs.push_back(mk("T2 lane1",   0, 4'h0, 32'h000, 32'h0,         32'h0,         0,    1, 4'h2, 32'h010, 32'h0000AA00, 32'hDEADBEEF, 0));
      vecs.push_back(mk("T2 read",    1, 4'h0, 32'h010, 32'h0,         32'hDEADAAEF, 0,    0, 4'h0, 32'h000, 32'h0,         32'h0,         0));
      vecs.push_back(mk("T3 misal",   0, 4'h0, 32'h000, 32'h0,         32'h0,         0,    1, 4'h0, 32'h013, 32'h0,         32'h0,         1));
      vecs.push_back(mk("T3 oor wr",  0, 4'h0, 32'h000, 32'h0,         32'h0,         0,    1, 4'hF, 32'h200, 32'h12345678, 32'h0,         1));
      vecs.push_back(mk("T3 word0",   1, 4'h0, 32'h204, 32'h0,         32'h0,         1,    1, 4'h0, 32'h000, 32'h0,         32'h0,         0));
      vecs.push_back(mk("T4 collide", 1, 4'hF, 32'h020, 32'h11111111, 32'h0,         0,    1, 4'h3, 32'h020, 32'h22222222, 32'h0,         0));
      vecs.push_back(mk("T4 rb",      1, 4'h0, 32'h020, 32'h0,         32'h11112222, 0,    1, 4'h0, 32'h1FC, 32'h0,         32'h0,         0));
      vecs.push_back(mk("T5 rd-wr",   1, 4'h0, 32'h020, 32'h0,         EXP_T5,        0,    1, 4'hF, 32'h020, 32'h33333333, 32'h11112222, 0));
      vecs.push_back(mk("T5 rb",      1, 4'h0, 32'h020, 32'h0,         32'h33333333, 0,    1, 4'h0, 32'h010, 32'h0,         32'hDEADAAEF, 0));
      vecs.push_back(mk("disjoint",   1, 4'hC, 32'h024, 32'hAABBCCDD, 32'h0,         0,    1, 4'h3, 32'h024, 32'h11223344, 32'h0,         0));
      vecs.push_back(mk("disj rb",    1, 4'h0, 32'h024, 32'h0,         32'hAABB3344, 0,    1, 4'h0, 32'h1FF, 32'h0,         32'h0,         1));
      vecs.push_back(mk("edge wr",    1, 4'h8, 32'h1FC, 32'h99000000, 32'h0,         0,    1, 4'h0, 32'h1FC, 32'h0,         EXP_EDGE,      0));
      vecs.push_back(mk("edge rb",    1, 4'h0, 32'h1FC, 32'h0,         32'h99000000, 0,    1, 4'h0, 32'hFFFFFFFC, 32'h0,      32'h0,         1));
      vecs.push_back(mk("I err wr",   1, 4'hF, 32'h201, 32'hDEADDEAD, 32'h0,         1,    1, 4'h0, 32'h000, 32'h0,         32'h0,         0));
      vecs.push_back(mk("dropped",    1, 4'h0, 32'h000, 32'h0,         32'h0,         0,    1, 4'h0, 32'h010, 32'h0,         32'hDEADAAEF, 0));
      vecs.push_back(mk("last I",     1, 4'h0, 32'h024, 32'h0,         32'hAABB3344, 0,    0, 4'h0, 32'h000, 32'h0,         32'h0,         0));

      repeat (3) @(negedge clk);
      check("rst ready", 32'(ready), 32'd0);
      check("rst rvalid_i", 32'(bus_i.rvalid), 32'd0);
      check("rst err_m", 32'(bus_m.err), 32'd0);
      check("rst data_out_m", bus_m.data_out, 32'h0);

      // Requests held through INIT must be ignored: no response and no write.
      bus_m.req = 1'b1; bus_m.we = 4'hF; bus_m.addr = 32'h1FC; bus_m.data_in = 32'hFFFFFFFF;
      bus_i.req = 1'b1; bus_i.addr = 32'h0;
      rst_n = 1'b1;
      mon_en = 1'b1;
      wait_ready("init length");

      foreach (vecs[k]) drive(vecs[k]);
      @(negedge clk);
      set_idle();
      @(negedge clk);
      check("hold data_out_i", bus_i.data_out, 32'hAABB3344);
      check("hold data_out_m", bus_m.data_out, 32'hDEADAAEF);

      // Back-to-back reads, then a reset pulse while a response is in flight.
      for (int k = 0; k < 3; k++)
         drive(mk("b2b", 1, 4'h0, 32'h010, 32'h0, 32'hDEADAAEF, 0, 1, 4'h0, 32'h020, 32'h0, 32'h33333333, 0));
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      q_i.delete();
      q_m.delete();
      #1;
      check("midrst rvalid_i", 32'(bus_i.rvalid), 32'd0);
      check("midrst rvalid_m", 32'(bus_m.rvalid), 32'd0);
      check("midrst ready", 32'(ready), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (50) @(negedge clk);
      // Reset again partway through the sweep; it must restart from word 0.
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      wait_ready("init restart length");

      drive(mk("T1 cleared", 1, 4'h0, 32'h010, 32'h0, 32'h0, 0, 1, 4'h0, 32'h1FC, 32'h0, 32'h0, 0));
      drive(mk("T1 cleared2", 1, 4'h0, 32'h020, 32'h0, 32'h0, 0, 1, 4'h0, 32'h024, 32'h0, 32'h0, 0));
      @(negedge clk);
      set_idle();
      repeat (2) @(negedge clk);
      check("scoreboard I drained", 32'(q_i.size()), 32'd0);
      check("scoreboard M drained", 32'(q_m.size()), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
